// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: states, instruction
// classes, opcode/funct values, datapath mux selects and trap causes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_BR, S_JMP, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_MEMLD, CL_MEMST, CL_IMM, CL_BR, CL_JMP, CL_JR, CL_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;

    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_SHAMT = 2'b01;
    localparam logic [1:0] SRCA_RS    = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALUOUT = 2'b00;
    localparam logic [1:0] PCSRC_ALU    = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle FSM (master) and the datapath/memory
// side (slave): IR fields and mem_ready in, all datapath strobes out.
interface mc_if #(parameter int OP_W = 6);
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    logic            mem_ready;
    logic            mem_req, MemRead, MemWrite, IorD;
    logic            IRWrite, PCWrite, PCWriteCond, RegWrite;
    logic            MemtoReg, ExtOp, LuiOp;
    logic [1:0]      RegDst, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0]      ALUOp;
    logic            retired, trap;
    logic [1:0]      trap_cause;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               RegWrite, MemtoReg, ExtOp, LuiOp, RegDst, ALUSrcA, ALUSrcB,
               PCSource, ALUOp, retired, trap, trap_cause
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
               RegWrite, MemtoReg, ExtOp, LuiOp, RegDst, ALUSrcA, ALUSrcB,
               PCSource, ALUOp, retired, trap, trap_cause
    );
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational opcode/funct to instruction-class decoder.
module mc_decode
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] i_opcode,
    input  logic [OP_W-1:0] i_funct,
    output iclass_t         o_class
);

    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_opcode)
            OP_W'(OP_RTYPE):
                o_class = (i_funct == OP_W'(FN_JR) || i_funct == OP_W'(FN_JALR)) ? CL_JR : CL_R;
            OP_W'(OP_LW):                                 o_class = CL_MEMLD;
            OP_W'(OP_SW):                                 o_class = CL_MEMST;
            OP_W'(OP_ADDI), OP_W'(OP_ADDIU), OP_W'(OP_LUI): o_class = CL_IMM;
            OP_W'(OP_BEQ):                                o_class = CL_BR;
            OP_W'(OP_J), OP_W'(OP_JAL):                   o_class = CL_JMP;
            default:                                      o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM with request/ready memory handshake,
// retire pulse and trapping. MC_TIMEOUT_EN enables the memory-wait timeout.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

`ifdef MC_TIMEOUT_EN
    localparam bit LP_TO_EN = 1'b1;
`else
    localparam bit LP_TO_EN = 1'b0;
`endif

    state_t           r_state, w_next;
    logic [1:0]       r_trap_cause, w_cause;
    logic [CNT_W-1:0] r_wait_cnt;
    iclass_t          w_class;
    logic             w_mem_phase, w_timeout, w_is_lui, w_is_jal, w_is_jalr, w_is_shift;

    mc_decode #(.OP_W(OP_W)) u_decode (
        .i_opcode (bus.opcode),
        .i_funct  (bus.funct),
        .o_class  (w_class)
    );

    assign w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);
    assign w_is_lui    = bus.opcode == OP_W'(OP_LUI);
    assign w_is_jal    = bus.opcode == OP_W'(OP_JAL);
    assign w_is_jalr   = (w_class == CL_JR) && (bus.funct == OP_W'(FN_JALR));
    assign w_is_shift  = (bus.funct == OP_W'(FN_SLL)) || (bus.funct == OP_W'(FN_SRL)) ||
                         (bus.funct == OP_W'(FN_SRA));
    // Fires on the wait cycle that brings the count to TIMEOUT_CYC, so the
    // request is dropped on the following cycle. Constant 0 when disabled.
    assign w_timeout   = LP_TO_EN && w_mem_phase && !bus.mem_ready &&
                         (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IF;
            r_trap_cause <= TRAP_NONE;
            r_wait_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_trap_cause <= w_cause;
            if (w_next != r_state || bus.mem_ready)
                r_wait_cnt <= '0;
            else if (w_mem_phase && r_wait_cnt != '1)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next  = r_state;
        w_cause = TRAP_TIMEOUT;
        case (r_state)
            S_IF: begin
                if (bus.mem_ready)  w_next = S_ID;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_ID: begin
                case (w_class)
                    CL_R, CL_MEMLD, CL_MEMST, CL_IMM: w_next = S_EX;
                    CL_BR:                            w_next = S_BR;
                    CL_JMP, CL_JR:                    w_next = S_JMP;
                    default: begin
                        w_next  = S_TRAP;
                        w_cause = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_EX:  w_next = (w_class == CL_MEMLD || w_class == CL_MEMST) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.mem_ready)  w_next = (w_class == CL_MEMST) ? S_IF : S_WB;
                else if (w_timeout) w_next = S_TRAP;
            end
            default: w_next = S_IF;
        endcase
    end

    assign bus.trap_cause = r_trap_cause;

    // Gated by reset so an in-flight request drops the moment reset asserts.
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.ExtOp       = 1'b0;
        bus.LuiOp       = 1'b0;
        bus.RegDst      = REGDST_RA;
        bus.ALUSrcA     = SRCA_PC;
        bus.ALUSrcB     = SRCB_RT;
        bus.PCSource    = PCSRC_ALUOUT;
        bus.ALUOp       = ALU_ADD;
        bus.retired     = 1'b0;
        bus.trap        = 1'b0;
        if (reset) begin
            case (r_state)
                S_IF: begin
                    bus.mem_req  = 1'b1;
                    bus.MemRead  = 1'b1;
                    bus.ALUSrcB  = SRCB_FOUR;
                    bus.PCSource = PCSRC_ALU;
                    bus.IRWrite  = bus.mem_ready;
                    bus.PCWrite  = bus.mem_ready;
                end
                S_ID: bus.ALUSrcB = SRCB_IMM_SH2;
                S_EX: begin
                    if (w_class == CL_R) begin
                        bus.ALUSrcA = w_is_shift ? SRCA_SHAMT : SRCA_RS;
                        bus.ALUOp   = ALU_FUNCT;
                    end else begin
                        bus.ALUSrcA = SRCA_RS;
                        bus.ALUSrcB = SRCB_IMM;
                        bus.LuiOp   = w_is_lui;
                        bus.ExtOp   = !w_is_lui;
                    end
                end
                S_MEM: begin
                    bus.mem_req  = 1'b1;
                    bus.IorD     = 1'b1;
                    bus.MemRead  = (w_class == CL_MEMLD);
                    bus.MemWrite = (w_class == CL_MEMST);
                    bus.retired  = (w_class == CL_MEMST) && bus.mem_ready;
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = (w_class == CL_R) ? REGDST_RD : REGDST_RT;
                    bus.MemtoReg = (w_class == CL_MEMLD);
                    bus.retired  = 1'b1;
                end
                S_BR: begin
                    bus.ALUSrcA     = SRCA_RS;
                    bus.PCWriteCond = 1'b1;
                    bus.ALUOp       = ALU_SUB;
                    bus.retired     = 1'b1;
                end
                S_JMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = (w_class == CL_JR) ? PCSRC_RS : PCSRC_JUMP;
                    bus.RegWrite = w_is_jal || w_is_jalr;
                    bus.RegDst   = w_is_jalr ? REGDST_RD : REGDST_RA;
                    bus.retired  = 1'b1;
                end
                S_TRAP: bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle vector table through a
// scoreboard queue, plus hand sequences for timeout and async reset.
module tb_mc_ctrl_fsm;
    import mc_pkg::*;

    typedef struct packed {
        logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
        logic       RegWrite, MemtoReg, ExtOp, LuiOp;
        logic [1:0] RegDst, ALUSrcA, ALUSrcB, PCSource;
        logic [3:0] ALUOp;
        logic       retired, trap;
        logic [1:0] trap_cause;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_if #(.OP_W(6)) bus();

    mc_ctrl_fsm #(.OP_W(6), .TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    out_t act;
    assign act = {bus.mem_req, bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
                  bus.PCWriteCond, bus.RegWrite, bus.MemtoReg, bus.ExtOp, bus.LuiOp, bus.RegDst,
                  bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.retired, bus.trap,
                  bus.trap_cause};

    int    n_cmp = 0;
    int    n_bad = 0;
    out_t  sb_q[$];
    string sb_n[$];
    out_t  sb_e;
    string sb_name;
    logic [1:0] tc = TRAP_NONE;
    vec_t  vt[$];

    task automatic chk(string name, out_t a, out_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_e    = sb_q.pop_front();
            sb_name = sb_n.pop_front();
            chk(sb_name, act, sb_e);
        end
    end

    function automatic out_t o_if(logic r);
        out_t o = '0;
        o.mem_req = 1; o.MemRead = 1; o.ALUSrcB = 2'b01; o.PCSource = 2'b01;
        o.IRWrite = r; o.PCWrite = r;
        return o;
    endfunction
    function automatic out_t o_id();
        out_t o = '0;
        o.ALUSrcB = 2'b11;
        return o;
    endfunction
    function automatic out_t o_exr(logic sh);
        out_t o = '0;
        o.ALUSrcA = sh ? 2'b01 : 2'b10; o.ALUOp = ALU_FUNCT;
        return o;
    endfunction
    function automatic out_t o_exi(logic lui);
        out_t o = '0;
        o.ALUSrcA = 2'b10; o.ALUSrcB = 2'b10; o.ExtOp = !lui; o.LuiOp = lui;
        return o;
    endfunction
    function automatic out_t o_mem(logic st, logic r);
        out_t o = '0;
        o.mem_req = 1; o.IorD = 1; o.MemRead = !st; o.MemWrite = st; o.retired = st & r;
        return o;
    endfunction
    function automatic out_t o_wb(logic rt, logic ld);
        out_t o = '0;
        o.RegWrite = 1; o.RegDst = rt ? 2'b10 : 2'b01; o.MemtoReg = ld; o.retired = 1;
        return o;
    endfunction
    function automatic out_t o_br();
        out_t o = '0;
        o.ALUSrcA = 2'b10; o.PCWriteCond = 1; o.ALUOp = ALU_SUB; o.retired = 1;
        return o;
    endfunction
    function automatic out_t o_jmp(logic reg_tgt, logic link);
        out_t o = '0;
        o.PCWrite = 1; o.PCSource = reg_tgt ? 2'b10 : 2'b11; o.RegWrite = link;
        o.RegDst = (reg_tgt & link) ? 2'b10 : 2'b00; o.retired = 1;
        return o;
    endfunction
    function automatic out_t o_trap(logic [1:0] cause);
        out_t o = '0;
        o.trap = 1; o.trap_cause = cause;
        return o;
    endfunction

    task automatic add(logic [5:0] op, logic [5:0] fn, logic rdy, out_t e);
        vec_t v;
        v.op = op; v.fn = fn; v.rdy = rdy; v.exp = e;
        vt.push_back(v);
    endtask

    // Drives one cycle starting just after a rising edge; checked at the falling edge.
    task automatic drive(string name, logic [5:0] op, logic [5:0] fn, logic rdy, out_t e);
        bus.opcode = op; bus.funct = fn; bus.mem_ready = rdy;
        if (e.trap) tc = e.trap_cause;
        else        e.trap_cause = tc;
        sb_q.push_back(e); sb_n.push_back(name);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        // add: zero wait, mem_ready left high in non-memory states
        add(6'h00, 6'h20, 1, o_if(1)); add(6'h00, 6'h20, 1, o_id());
        add(6'h00, 6'h20, 1, o_exr(0)); add(6'h00, 6'h20, 1, o_wb(1, 0));
        // lw: three wait states on fetch and on data access
        for (int i = 0; i < 3; i++) add(6'h23, 6'h00, 0, o_if(0));
        add(6'h23, 6'h00, 1, o_if(1)); add(6'h23, 6'h00, 0, o_id());
        add(6'h23, 6'h00, 0, o_exi(0));
        for (int i = 0; i < 3; i++) add(6'h23, 6'h00, 0, o_mem(0, 0));
        add(6'h23, 6'h00, 1, o_mem(0, 1)); add(6'h23, 6'h00, 0, o_wb(0, 1));
        // sw: one data wait state, retires on ready
        add(6'h2B, 6'h00, 1, o_if(1)); add(6'h2B, 6'h00, 0, o_id());
        add(6'h2B, 6'h00, 0, o_exi(0)); add(6'h2B, 6'h00, 0, o_mem(1, 0));
        add(6'h2B, 6'h00, 1, o_mem(1, 1));
        add(6'h04, 6'h00, 1, o_if(1)); add(6'h04, 6'h00, 0, o_id()); add(6'h04, 6'h00, 0, o_br());
        add(6'h03, 6'h00, 1, o_if(1)); add(6'h03, 6'h00, 0, o_id()); add(6'h03, 6'h00, 0, o_jmp(0, 1));
        add(6'h02, 6'h00, 1, o_if(1)); add(6'h02, 6'h00, 0, o_id()); add(6'h02, 6'h00, 0, o_jmp(0, 0));
        add(6'h00, 6'h09, 1, o_if(1)); add(6'h00, 6'h09, 0, o_id()); add(6'h00, 6'h09, 0, o_jmp(1, 1));
        add(6'h00, 6'h08, 1, o_if(1)); add(6'h00, 6'h08, 0, o_id()); add(6'h00, 6'h08, 0, o_jmp(1, 0));
        add(6'h00, 6'h02, 1, o_if(1)); add(6'h00, 6'h02, 0, o_id());
        add(6'h00, 6'h02, 0, o_exr(1)); add(6'h00, 6'h02, 0, o_wb(1, 0));
        add(6'h0F, 6'h00, 1, o_if(1)); add(6'h0F, 6'h00, 0, o_id());
        add(6'h0F, 6'h00, 0, o_exi(1)); add(6'h0F, 6'h00, 0, o_wb(0, 0));
        add(6'h08, 6'h00, 1, o_if(1)); add(6'h08, 6'h00, 0, o_id());
        add(6'h08, 6'h00, 0, o_exi(0)); add(6'h08, 6'h00, 0, o_wb(0, 0));
        // illegal opcode, then an add with the cause still held
        add(6'h3F, 6'h00, 1, o_if(1)); add(6'h3F, 6'h00, 0, o_id());
        add(6'h3F, 6'h00, 0, o_trap(TRAP_ILLEGAL)); add(6'h00, 6'h20, 0, o_if(0));
        add(6'h00, 6'h20, 1, o_if(1)); add(6'h00, 6'h20, 0, o_id());
        add(6'h00, 6'h20, 0, o_exr(0)); add(6'h00, 6'h20, 0, o_wb(1, 0));

        bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b1;
        #12;
        chk("reset_outputs", act, '0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++)
            drive($sformatf("v%0d", i), vt[i].op, vt[i].fn, vt[i].rdy, vt[i].exp);

`ifdef MC_TIMEOUT_EN
        for (int i = 0; i < 16; i++) drive($sformatf("to_if%0d", i), 6'h00, 6'h20, 0, o_if(0));
        drive("to_trap", 6'h00, 6'h20, 0, o_trap(TRAP_TIMEOUT));
`else
        for (int i = 0; i < 100; i++) drive($sformatf("hold_if%0d", i), 6'h00, 6'h20, 0, o_if(0));
`endif
        drive("post_if", 6'h00, 6'h20, 1, o_if(1));
        drive("post_id", 6'h00, 6'h20, 0, o_id());
        drive("post_ex", 6'h00, 6'h20, 0, o_exr(0));
        drive("post_wb", 6'h00, 6'h20, 0, o_wb(1, 0));

        // sw interrupted by reset while waiting in the data access
        drive("rs_if", 6'h2B, 6'h00, 1, o_if(1));
        drive("rs_id", 6'h2B, 6'h00, 0, o_id());
        drive("rs_ex", 6'h2B, 6'h00, 0, o_exi(0));
        bus.mem_ready = 1'b0;
        #1;
        chk("rs_mem_pre", act, o_mem(1, 0) | out_t'(tc));
        rst_n = 1'b0;
        #1;
        chk("rs_async_zero", act, '0);
        tc = TRAP_NONE;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("rs_release_if", act, o_if(0));
        drive("rs2_if", 6'h2B, 6'h00, 1, o_if(1));
        drive("rs2_id", 6'h2B, 6'h00, 0, o_id());
        drive("rs2_ex", 6'h2B, 6'h00, 0, o_exi(0));
        drive("rs2_mem", 6'h2B, 6'h00, 1, o_mem(1, 1));
        drive("rs2_if_next", 6'h2B, 6'h00, 0, o_if(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
